// File: rtl/bcd_serial_adder_ctrl_if.sv
// rtl/bcd_serial_adder_ctrl_if.sv - host/adder handshake bundle for the serial BCD adder
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   addend;
  logic [4*DIGITS-1:0]   augend;
  logic                  carry_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry_out;
  logic                  error;

  // Host side: issues operands, observes status and result
  modport master (
    output start, addend, augend, carry_in,
    input  busy, done, sum, carry_out, error
  );

  // Adder side: consumes operands, produces status and result
  modport slave (
    input  start, addend, augend, carry_in,
    output busy, done, sum, carry_out, error
  );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// rtl/bcd_serial_adder_ctrl.sv - digit-serial packed-BCD adder sequencer (optional BCD_INVALID_CHECK_EN)
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  bcd_serial_adder_ctrl_if.slave   bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    r;
  logic            c;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    sum_q;
  logic            carry_q;

  logic [4:0]      raw;
  logic [4:0]      adj;
  logic [3:0]      digit;
  logic            c_next;
  logic [W+3:0]    r_cat;

  // Single-digit BCD add step on the current low digits plus the running carry
  always_comb begin
    raw    = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, c};
    adj    = raw + 5'd6;
    digit  = raw[3:0];
    c_next = 1'b0;
    if (raw > 5'd9) begin
      digit  = adj[3:0];
      c_next = 1'b1;
    end
    r_cat  = {digit, r};
  end

  // Sequencer: latch on start, one digit per ADD cycle, publish result in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      r       <= '0;
      c       <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.addend;
            b_sh   <= bus.augend;
            c      <= bus.carry_in;
            r      <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          // result digits enter at the top so digit 0 ends up in the low nibble
          r    <= r_cat[W+3:4];
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end
        DONE: begin
          sum_q   <= r;
          carry_q <= c;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic bad_flag;
  logic err_q;
  logic digit_bad;

  assign digit_bad = (a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9);

  // Sticky non-BCD digit detector, reported alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_flag <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bad_flag <= 1'b0;
          end
        end
        ADD: begin
          if (digit_bad) begin
            bad_flag <= 1'b1;
          end
        end
        DONE: begin
          err_q <= bad_flag;
        end
        default: begin
          bad_flag <= 1'b0;
        end
      endcase
    end
  end

  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb/tb_bcd_serial_adder_ctrl.sv - directed self-checking bench for bcd_serial_adder_ctrl
module tb_bcd_serial_adder_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_serial_adder_ctrl_if #(.DIGITS(4)) bus  ();
  bcd_serial_adder_ctrl_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bcd_serial_adder_ctrl #(.DIGITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, output int lat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.addend   = a;
    bus.augend   = b;
    bus.carry_in = ci;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int first;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start     = 1'b0;
    bus.addend    = '0;
    bus.augend    = '0;
    bus.carry_in  = 1'b0;
    bus1.start    = 1'b0;
    bus1.addend   = '0;
    bus1.augend   = '0;
    bus1.carry_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_busy",  64'(bus.busy), 64'h0);
    chk("rst_done",  64'(bus.done), 64'h0);
    chk("rst_sum",   64'(bus.sum), 64'h0);
    chk("rst_cout",  64'(bus.carry_out), 64'h0);
    chk("rst_error", 64'(bus.error), 64'h0);

    // 1234 + 5678 = 6912
    run_op(16'h1234, 16'h5678, 1'b0, lat);
    chk("add1_lat",  64'(lat), 64'd5);
    chk("add1_sum",  64'(bus.sum), 64'h6912);
    chk("add1_cout", 64'(bus.carry_out), 64'h0);
    @(posedge clk);
    #1;
    chk("add1_done_pulse", 64'(bus.done), 64'h0);
    chk("add1_sum_hold",   64'(bus.sum), 64'h6912);

    // 9999 + 0001 = 1_0000
    run_op(16'h9999, 16'h0001, 1'b0, lat);
    chk("add2_lat",  64'(lat), 64'd5);
    chk("add2_sum",  64'(bus.sum), 64'h0000);
    chk("add2_cout", 64'(bus.carry_out), 64'h1);

    // 0000 + 0000 + carry_in = 0001
    run_op(16'h0000, 16'h0000, 1'b1, lat);
    chk("add3_lat",  64'(lat), 64'd5);
    chk("add3_sum",  64'(bus.sum), 64'h0001);
    chk("add3_cout", 64'(bus.carry_out), 64'h0);

    // 0005 + 0005 with a second start two cycles in, which must be ignored
    @(negedge clk);
    bus.start    = 1'b1;
    bus.addend   = 16'h0005;
    bus.augend   = 16'h0005;
    bus.carry_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    first  = 0;
    @(posedge clk);
    #1;
    chk("busy_in_add", 64'(bus.busy), 64'h1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.addend   = 16'h1111;
    bus.augend   = 16'h1111;
    bus.carry_in = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("sum_held_while_busy", 64'(bus.sum), 64'h0001);
    for (int n = 3; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    chk("ignore_pulses", 64'(pulses), 64'd1);
    chk("ignore_lat",    64'(first), 64'd5);
    chk("ignore_sum",    64'(bus.sum), 64'h0010);
    chk("ignore_cout",   64'(bus.carry_out), 64'h0);

    // reset in the middle of 4999 + 5001
    @(negedge clk);
    bus.start    = 1'b1;
    bus.addend   = 16'h4999;
    bus.augend   = 16'h5001;
    bus.carry_in = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sum",  64'(bus.sum), 64'h0);
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    chk("midrst_done", 64'(bus.done), 64'h0);
    chk("midrst_cout", 64'(bus.carry_out), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    run_op(16'h0001, 16'h0002, 1'b0, lat);
    chk("postrst_lat", 64'(lat), 64'd5);
    chk("postrst_sum", 64'(bus.sum), 64'h0003);

    // invalid digit: arithmetic unchanged, error only with the check built in
    run_op(16'h00A0, 16'h0000, 1'b0, lat);
    chk("inv_lat",  64'(lat), 64'd5);
    chk("inv_sum",  64'(bus.sum), 64'h0100);
    chk("inv_cout", 64'(bus.carry_out), 64'h0);
`ifdef BCD_INVALID_CHECK_EN
    chk("inv_error", 64'(bus.error), 64'h1);
`else
    chk("inv_error", 64'(bus.error), 64'h0);
`endif
    run_op(16'h0011, 16'h0022, 1'b0, lat);
    chk("valid_sum",   64'(bus.sum), 64'h0033);
    chk("valid_error", 64'(bus.error), 64'h0);

    // single-digit instance: 8 + 7 + 1 = 16
    @(negedge clk);
    bus1.start    = 1'b1;
    bus1.addend   = 4'h8;
    bus1.augend   = 4'h7;
    bus1.carry_in = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (bus1.done) begin
        lat = n;
        break;
      end
    end
    chk("d1_lat",  64'(lat), 64'd2);
    chk("d1_sum",  64'(bus1.sum), 64'h6);
    chk("d1_cout", 64'(bus1.carry_out), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
